// File: rtl/keypoint_collector.sv
// Raster-order keypoint collector: tracks (x,y) of detector result beats,
// queues keypoint coordinates in a show-ahead FIFO and reports per-frame counts.
// Optional build macro KP_BORDER_MASK_EN discards keypoints on the outer interior ring.
module keypoint_collector #(
    parameter int unsigned N          = 480,
    parameter int unsigned M          = 320,
    parameter int unsigned CW         = 9,
    parameter int unsigned FIFO_DEPTH = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          kp_valid,
    input  logic [7:0]    kp_flag,
    input  logic          ovf_clr,
    output logic          kp_out_valid,
    input  logic          kp_out_ready,
    output logic [CW-1:0] kp_x,
    output logic [CW-1:0] kp_y,
    output logic          frame_done,
    output logic [15:0]   kp_count,
    output logic          overflow
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned OW = AW + 1;
    localparam int unsigned DW = 2 * CW;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic [15:0]   run_cnt;

    logic [DW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [OW-1:0] occ;

    logic          is_kp_c;
    logic          last_beat_c;
    logic          full_c;
    logic          push_c;
    logic          pop_c;
    logic          drop_c;
    logic [15:0]   cnt_base_c;
    logic [15:0]   cnt_next_c;
    logic [AW-1:0] rd_next_c;
    logic [OW-1:0] occ_left_c;
    logic [OW-1:0] occ_next_c;
    logic [DW-1:0] head_next_c;

    // Beat classification, running count, FIFO occupancy and next head entry
    always_comb begin
`ifdef KP_BORDER_MASK_EN
        is_kp_c = kp_valid && (|kp_flag) &&
                  !((x == CW'(1)) || (x == CW'(M - 2)) || (y == CW'(1)) || (y == CW'(N - 2)));
`else
        is_kp_c = kp_valid && (|kp_flag);
`endif
        last_beat_c = kp_valid && (x == CW'(M - 2)) && (y == CW'(N - 2));

        // A beat outside RUN is the first beat of a frame, so the count restarts
        cnt_base_c = (state == RUN) ? run_cnt : 16'd0;
        cnt_next_c = cnt_base_c;
        if (is_kp_c && (cnt_base_c != 16'hFFFF)) begin
            cnt_next_c = cnt_base_c + 16'd1;
        end

        // Fullness uses start-of-cycle occupancy; a same-cycle pop does not rescue a push
        full_c = (occ == OW'(FIFO_DEPTH));
        push_c = is_kp_c && !full_c;
        drop_c = is_kp_c && full_c;
        pop_c  = kp_out_valid && kp_out_ready;

        rd_next_c  = pop_c ? (rd_ptr + AW'(1)) : rd_ptr;
        occ_left_c = occ - OW'(pop_c);
        occ_next_c = occ_left_c + OW'(push_c);

        // When the queue drains to empty this cycle the new write becomes the head
        head_next_c = {kp_x, kp_y};
        if (occ_next_c != '0) begin
            head_next_c = (occ_left_c == '0) ? {x, y} : mem[rd_next_c];
        end
    end

    // Frame FSM with coordinate tracking, per-frame count and end-of-frame pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            x          <= CW'(1);
            y          <= CW'(1);
            run_cnt    <= 16'd0;
            frame_done <= 1'b0;
            kp_count   <= 16'd0;
        end else begin
            frame_done <= last_beat_c;
            run_cnt    <= cnt_next_c;
            if (last_beat_c) begin
                kp_count <= cnt_next_c;
            end
            if (kp_valid) begin
                if (x == CW'(M - 2)) begin
                    x <= CW'(1);
                    y <= (y == CW'(N - 2)) ? CW'(1) : (y + CW'(1));
                end else begin
                    x <= x + CW'(1);
                end
            end
            case (state)
                IDLE: begin
                    if (kp_valid) begin
                        state <= last_beat_c ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (last_beat_c) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (kp_valid) begin
                        state <= last_beat_c ? DONE : RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // FIFO pointers, occupancy, registered head and sticky overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            occ          <= '0;
            kp_out_valid <= 1'b0;
            kp_x         <= '0;
            kp_y         <= '0;
            overflow     <= 1'b0;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr       <= rd_next_c;
            occ          <= occ_next_c;
            kp_out_valid <= (occ_next_c != '0);
            kp_x         <= head_next_c[DW-1:CW];
            kp_y         <= head_next_c[CW-1:0];
            if (drop_c) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    // FIFO storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr] <= {x, y};
        end
    end

endmodule
